block_mem_arbiter: RTL and testbench

- Sits between the pipelined MIPS core's two caches and the single main-memory port.
- Accepts 256-bit block read (refill) and block write (writeback) requests from the iCache and the dCache.
- Serialises them onto one request/acknowledge memory interface and returns refill data with a one-cycle completion pulse.
- Arbitration is round-robin. A dCache writeback+refill pair is handled as one atomic grant.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/block_mem_arbiter_rr_pick2.sv | 23 ++
 rtl/block_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_block_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the cache-to-memory block arbiter.
package mem_arb_pkg;

  localparam int unsigned BLK_W_DEF = 256;
  localparam int unsigned OFF_W_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

endpackage

// File: rtl/block_mem_arbiter_rr_pick2.sv
// Two-requester round-robin picker; on a tie the side opposite `last` wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic grant_valid,
  output logic grant_side
);

  always_comb begin
    grant_valid = req_i | req_d;
    if (req_i && req_d) begin
      grant_side = ~last;
    end else if (req_d) begin
      grant_side = SIDE_D;
    end else begin
      grant_side = SIDE_I;
    end
  end

endmodule

// File: rtl/block_mem_arbiter.sv
// Serialises iCache/dCache block refills and writebacks onto one memory port.
module block_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BLK_W  = BLK_W_DEF,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = OFF_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BLK_W-1:0]  i_wdata,
  output logic [BLK_W-1:0]  i_rdata,
  output logic              i_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic [BLK_W-1:0]  d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              side_q, side_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BLK_W-1:0]  wdata_q, wdata_d;
  logic [BLK_W-1:0]  i_rdata_q, i_rdata_d;
  logic [BLK_W-1:0]  d_rdata_q, d_rdata_d;

  logic grant_valid, grant_side;

  rr_pick2 u_pick (
    .req_i       (i_rd | i_wr),
    .req_d       (d_rd | d_wr),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_side  (grant_side)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    side_d    = side_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          side_d = grant_side;
          if (grant_side == SIDE_D) begin
            addr_d  = d_addr & ALIGN_MASK;
            wdata_d = d_wdata;
            rd_d    = d_rd;
            state_d = d_wr ? ST_WR : ST_RD;
          end else begin
            addr_d  = i_addr & ALIGN_MASK;
            wdata_d = i_wdata;
            rd_d    = i_rd;
            state_d = i_wr ? ST_WR : ST_RD;
          end
        end
      end
      ST_WR: begin
        if (mem_ack) state_d = rd_q ? ST_RD : ST_DONE;
      end
      ST_RD: begin
        if (mem_ack) begin
          if (side_q == SIDE_D) d_rdata_d = mem_rdata;
          else                  i_rdata_d = mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = side_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      last_q    <= SIDE_D;
      side_q    <= SIDE_I;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      side_q    <= side_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops mem_req at once.
  assign mem_req   = (state_q == ST_WR) || (state_q == ST_RD);
  assign mem_we    = (state_q == ST_WR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign i_done    = (state_q == ST_DONE) && (side_q == SIDE_I);
  assign d_done    = (state_q == ST_DONE) && (side_q == SIDE_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_block_mem_arbiter.sv
// Scoreboard bench for block_mem_arbiter with a behavioural memory and arbitration model.
module tb_block_mem_arbiter;

  localparam int BLK_W  = 256;
  localparam int ADDR_W = 32;
  localparam int OFF_W  = 5;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              i_rd, i_wr, d_rd, d_wr;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [BLK_W-1:0]  i_wdata, d_wdata;
  logic [BLK_W-1:0]  i_rdata, d_rdata;
  logic              i_done, d_done;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata, mem_rdata;
  logic              busy;

  block_mem_arbiter #(.BLK_W(BLK_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata), .i_rdata(i_rdata), .i_done(i_done),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BLK_W-1:0]  wdata;
  } mop_t;

  typedef struct packed {
    logic             side;
    logic [BLK_W-1:0] exp_i;
    logic [BLK_W-1:0] exp_d;
  } cmp_t;

  mop_t mem_q[$];
  cmp_t done_q[$];

  int          tests_run = 0;
  int          failed    = 0;
  logic        last_m;
  logic [BLK_W-1:0] mi, md;
  int unsigned rd_n_model, rd_n_mem;
  int          ack_delay = -1;
  bit          resp_en   = 1'b1;
  bit          stray_ack = 1'b0;
  int          busy_cycles, req_cycles;
  bit          r_active;
  int          r_wait;
  mop_t        r_cur;

  function automatic logic [BLK_W-1:0] blk_of(logic [ADDR_W-1:0] a, int unsigned n);
    logic [31:0] w;
    w = a ^ (n * 32'h9E37_79B9);
    return {8{w}};
  endfunction

  task automatic chk(string nm, logic [BLK_W-1:0] act, logic [BLK_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    tests_run++;
    failed++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Memory responder: checks each transaction against the expected stream, acks after a delay.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    r_active = 1'b0;
    r_wait = 0;
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      if (!RESET) begin
        r_active = 1'b0;
      end else if (mem_req && resp_en) begin
        if (!r_active) begin
          if (mem_q.size() == 0) begin
            bad("unexpected_mem_req");
            r_cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
          end else begin
            r_cur = mem_q.pop_front();
          end
          r_active = 1'b1;
          r_wait = (ack_delay < 0) ? int'($urandom_range(3, 0)) : ack_delay;
        end
        chk("mem_we", mem_we, r_cur.we);
        chk("mem_addr", mem_addr, r_cur.addr);
        if (r_cur.we) chk("mem_wdata", mem_wdata, r_cur.wdata);
        if (r_wait == 0) begin
          mem_ack = 1'b1;
          if (r_cur.we) begin
            mem_rdata = {8{$urandom}};
          end else begin
            mem_rdata = blk_of(r_cur.addr, rd_n_mem);
            rd_n_mem++;
          end
          r_active = 1'b0;
        end else begin
          r_wait--;
        end
      end else if (stray_ack) begin
        mem_ack = 1'b1;
        mem_rdata = {8{$urandom}};
        stray_ack = 1'b0;
      end
    end
  end

  // Completion monitor.
  initial begin
    cmp_t e;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        if (busy) busy_cycles++;
        if (mem_req) req_cycles++;
        if (i_done || d_done) begin
          if (i_done && d_done) bad("both_done");
          if (done_q.size() == 0) begin
            bad("unexpected_done");
          end else begin
            e = done_q.pop_front();
            chk("done_side", d_done, e.side);
            chk("i_rdata", i_rdata, e.exp_i);
            chk("d_rdata", d_rdata, e.exp_d);
          end
        end
      end
    end
  end

  task automatic model_serve(input logic side, input logic r, input logic w,
                             input logic [ADDR_W-1:0] a, input logic [BLK_W-1:0] wd);
    logic [ADDR_W-1:0] al;
    logic [BLK_W-1:0]  nb;
    al = (a >> OFF_W) << OFF_W;
    if (w) mem_q.push_back('{we: 1'b1, addr: al, wdata: wd});
    if (r) begin
      mem_q.push_back('{we: 1'b0, addr: al, wdata: '0});
      nb = blk_of(al, rd_n_model);
      rd_n_model++;
      if (side) md = nb;
      else      mi = nb;
    end
    done_q.push_back('{side: side, exp_i: mi, exp_d: md});
    last_m = side;
  endtask

  task automatic txn(input bit iv, input bit ir, input bit iw, input logic [ADDR_W-1:0] ia,
                     input bit dv, input bit dr, input bit dw, input logic [ADDR_W-1:0] da);
    logic [BLK_W-1:0] iwd, dwd;
    bit ip, dp;
    int n;
    iwd = {8{$urandom}};
    dwd = {8{$urandom}};
    if (iv && dv) begin
      if (last_m) begin
        model_serve(1'b0, ir, iw, ia, iwd);
        model_serve(1'b1, dr, dw, da, dwd);
      end else begin
        model_serve(1'b1, dr, dw, da, dwd);
        model_serve(1'b0, ir, iw, ia, iwd);
      end
    end else if (iv) begin
      model_serve(1'b0, ir, iw, ia, iwd);
    end else if (dv) begin
      model_serve(1'b1, dr, dw, da, dwd);
    end
    i_rd = iv & ir; i_wr = iv & iw; i_addr = ia; i_wdata = iwd;
    d_rd = dv & dr; d_wr = dv & dw; d_addr = da; d_wdata = dwd;
    ip = iv;
    dp = dv;
    n = 0;
    while ((ip || dp) && n < 300) begin
      @(negedge CLK);
      n++;
      if (i_done) begin i_rd = 1'b0; i_wr = 1'b0; ip = 1'b0; end
      if (d_done) begin d_rd = 1'b0; d_wr = 1'b0; dp = 1'b0; end
    end
    if (ip || dp) begin
      i_rd = 1'b0; i_wr = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      bad("txn_timeout");
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    mem_q.delete();
    done_q.delete();
    last_m = 1'b1;
    mi = '0;
    md = '0;
    rd_n_model = 0;
    rd_n_mem = 0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    bit ir, iw, dr, dw, iv, dv;
    int n;
    RESET = 1'b0;
    i_rd = 1'b0; i_wr = 1'b0; i_addr = '0; i_wdata = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    last_m = 1'b1; mi = '0; md = '0; rd_n_model = 0; rd_n_mem = 0;
    repeat (3) @(negedge CLK);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    RESET = 1'b1;
    @(negedge CLK);

    // iCache read, ack in first mem_req cycle: done in the 3rd cycle counting the request cycle.
    ack_delay = 0;
    model_serve(1'b0, 1'b1, 1'b0, 32'h0040_0014, '0);
    i_rd = 1'b1; i_addr = 32'h0040_0014;
    @(negedge CLK);
    chk("lat_req", mem_req, 1);
    chk("lat_addr", mem_addr, 32'h0040_0000);
    chk("lat_we", mem_we, 0);
    chk("lat_done_early", i_done, 0);
    @(negedge CLK);
    chk("lat_done", i_done, 1);
    i_rd = 1'b0;
    @(negedge CLK);
    chk("lat_idle", busy, 0);

    // dCache writeback + refill, ack delay 2 each, no gap in mem_req.
    ack_delay = 2;
    busy_cycles = 0; req_cycles = 0;
    txn(0, 0, 0, 0, 1, 1, 1, 32'h1000_0020);
    chk("wr_rd_busy", busy_cycles, 7);
    chk("wr_rd_req", req_cycles, 6);

    // Ties from reset: iCache first, then alternating.
    do_reset();
    ack_delay = -1;
    txn(1, 1, 0, 32'h0000_1000, 1, 1, 0, 32'h2000_0040);
    txn(1, 1, 0, 32'h0000_1100, 1, 1, 0, 32'h2000_0140);

    // Reset while RD is waiting for ack.
    resp_en = 1'b0;
    d_rd = 1'b1; d_addr = 32'h3000_0000;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge CLK); n++; end
    chk("abort_in_rd", mem_req && !mem_we, 1);
    #2 RESET = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_i_rdata", i_rdata, 0);
    chk("abort_d_rdata", d_rdata, 0);
    d_rd = 1'b0;
    resp_en = 1'b1;
    do_reset();
    repeat (2) @(negedge CLK);
    chk("abort_idle", busy, 0);

    // Stray ack in IDLE.
    ack_delay = 1;
    txn(1, 1, 0, 32'h0000_2000, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 1, 1, 0, 32'h4000_0060);
    stray_ack = 1'b1;
    repeat (3) @(negedge CLK);
    chk("stray_busy", busy, 0);
    chk("stray_i_rdata", i_rdata, mi);
    chk("stray_d_rdata", d_rdata, md);

    // dCache write-only with 4-cycle ack delay.
    ack_delay = 4;
    busy_cycles = 0;
    txn(0, 0, 0, 0, 1, 0, 1, 32'h5000_0080);
    chk("wo_busy", busy_cycles, 6);
    chk("wo_d_rdata", d_rdata, md);

    // Randomized traffic.
    ack_delay = -1;
    for (int unsigned k = 0; k < 40; k++) begin
      iv = 1'($urandom); dv = 1'($urandom);
      ir = 1'($urandom); iw = 1'($urandom); if (!ir && !iw) ir = 1'b1;
      dr = 1'($urandom); dw = 1'($urandom); if (!dr && !dw) dw = 1'b1;
      txn(iv, ir, iw, $urandom, dv, dr, dw, $urandom);
    end
    chk("end_mem_q_empty", mem_q.size(), 0);
    chk("end_done_q_empty", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
